timer_counter: RTL and testbench

Memory-mapped 32-bit down-counting timer on the processor's peripheral bus. It generates a hardware interrupt request that drives one bit of the coprocessor-0 `HWInt[5:0]` input. Software programs it through stores and loads routed by the system bridge. Two instances exist in the system: Timer0 on `HWInt[0]` and Timer1 on `HWInt[1]`.

---
 rtl/timer_counter_pkg.sv | 30 +++
 rtl/timer_counter_if.sv | 11 +
 rtl/timer_counter.sv | 128 ++++++++++++
 tb/tb_timer_counter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_counter_pkg.sv
// Shared constants for the memory-mapped down-counting timer.
package timer_pkg;

  // Word offsets on the peripheral bus (address bits [3:2])
  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } tc_state_e;

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // Only mode 01 reloads automatically; 00, 10 and 11 all behave as one-shot.
  function automatic logic is_periodic(input logic [1:0] mode);
    return (mode == MODE_PERIODIC);
  endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Peripheral bus slice seen by one timer instance: word select, store, load, interrupt.
interface timer_counter_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, we, wdata, input rdata, irq);
  modport slave  (input addr, we, wdata, output rdata, irq);
endinterface

// File: rtl/timer_counter.sv
// 32-bit down-counting timer with one-shot / periodic modes and a maskable interrupt.
//
//   state | meaning
//   ------+--------------------------------------------------------
//   IDLE  | waiting for En; COUNT holds its last value
//   LOAD  | COUNT <= PRESET (zero treated as one)
//   CNT   | decrementing; leaves on !En or when COUNT reaches <= 1
//   INT   | one cycle with flag raised; one-shot clears En here
module timer_counter
  import timer_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus
);

  tc_state_e   state, state_nxt;
  logic [3:0]  ctrl, ctrl_nxt;
  logic [31:0] preset, preset_nxt;
  logic [31:0] count, count_nxt;
  logic        flag, flag_nxt;
  logic        irq_q;
  logic [31:0] rdata;

  logic        en, im;
  logic [1:0]  mode;
  logic        wr_ctrl, wr_preset;
  logic        unused_wdata_hi;

  assign en   = ctrl[CTRL_EN];
  assign im   = ctrl[CTRL_IM];
  assign mode = ctrl[CTRL_MODE_HI:CTRL_MODE_LO];

  assign wr_ctrl   = bus.we && (bus.addr == TC_CTRL);
  assign wr_preset = bus.we && (bus.addr == TC_PRESET);

  // CTRL only keeps the low four bits of a store
  assign unused_wdata_hi = ^bus.wdata[31:4];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en) state_nxt = LOAD;
      LOAD: state_nxt = CNT;
      CNT: begin
        if (!en)                 state_nxt = IDLE;
        else if (count <= 32'd1) state_nxt = INT;
      end
      INT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Register next values: FSM effects first, then bus writes override them
  always_comb begin
    ctrl_nxt   = ctrl;
    preset_nxt = preset;
    count_nxt  = count;
    flag_nxt   = flag;

    case (state)
      LOAD: count_nxt = (preset == 32'd0) ? 32'd1 : preset;
      CNT: begin
        if (en) begin
          if (count > 32'd1) begin
            count_nxt = count - 32'd1;
          end else begin
            count_nxt = 32'd0;
            flag_nxt  = 1'b1;
          end
        end
      end
      INT: begin
        if (is_periodic(mode)) flag_nxt = 1'b0;
        else                   ctrl_nxt[CTRL_EN] = 1'b0;
      end
      default: ;
    endcase

    if (wr_ctrl) begin
      ctrl_nxt = bus.wdata[3:0];
      flag_nxt = 1'b0;
    end
    if (wr_preset) begin
      preset_nxt = bus.wdata;
      flag_nxt   = 1'b0;
    end
  end

  // Datapath registers; irq is registered from the next flag/IM so it lines up with INT entry
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl   <= 4'd0;
      preset <= 32'd0;
      count  <= 32'd0;
      flag   <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      ctrl   <= ctrl_nxt;
      preset <= preset_nxt;
      count  <= count_nxt;
      flag   <= flag_nxt;
      irq_q  <= flag_nxt & ctrl_nxt[CTRL_IM];
    end
  end

  // Load data mux; a same-cycle write is not yet visible here
  always_comb begin
    rdata = 32'd0;
    case (bus.addr)
      TC_CTRL:   rdata = {28'd0, ctrl};
      TC_PRESET: rdata = preset;
      TC_COUNT:  rdata = count;
      default:   rdata = 32'd0;
    endcase
  end

  assign bus.rdata = rdata;
  assign bus.irq   = irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: reset, one-shot, periodic, disable, masking, edges.
module tb_timer_counter;
  import timer_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  timer_counter_if bus_if();

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_if.addr  = a;
    bus_if.we    = 1'b1;
    bus_if.wdata = d;
    @(posedge clk);
    #1;
    bus_if.we    = 1'b0;
    bus_if.wdata = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus_if.addr = a;
    bus_if.we   = 1'b0;
    #1;
    d = bus_if.rdata;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] irq_val();
    return {31'd0, bus_if.irq};
  endfunction

  logic [31:0] rd;

  initial begin
    bus_if.addr  = 2'd0;
    bus_if.we    = 1'b0;
    bus_if.wdata = 32'd0;

    // Reset
    tick(1);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      check_eq($sformatf("reset rdata addr%0d", a), rd, 32'd0);
    end
    check_eq("reset irq", irq_val(), 32'd0);
    for (int k = 0; k < 20; k++) begin
      tick(1);
      bus_read(TC_COUNT, rd);
      check_eq("idle count", rd, 32'd0);
      check_eq("idle irq", irq_val(), 32'd0);
    end

    // One-shot, PRESET=5; also read-during-write returns old PRESET
    bus_if.addr  = TC_PRESET;
    bus_if.we    = 1'b1;
    bus_if.wdata = 32'd5;
    #1;
    check_eq("read during write", bus_if.rdata, 32'd0);
    @(posedge clk);
    #1;
    bus_if.we = 1'b0;
    bus_read(TC_PRESET, rd);
    check_eq("preset readback", rd, 32'd5);
    bus_write(TC_CTRL, 32'h9);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (k >= 2 && k <= 6) begin
        bus_read(TC_COUNT, rd);
        check_eq($sformatf("oneshot count E%0d", k), rd, 32'(7 - k));
      end
      check_eq($sformatf("oneshot irq E%0d", k), irq_val(), (k >= 7) ? 32'd1 : 32'd0);
    end
    bus_read(TC_CTRL, rd);
    check_eq("oneshot ctrl after int", rd, 32'h8);
    tick(3);
    check_eq("oneshot irq held", irq_val(), 32'd1);
    bus_write(TC_PRESET, 32'd5);
    check_eq("oneshot irq cleared", irq_val(), 32'd0);

    // Periodic, PRESET=3: INT every 6 cycles starting at E5
    reset_dut();
    bus_write(TC_PRESET, 32'd3);
    bus_write(TC_CTRL, 32'hB);
    for (int k = 1; k <= 24; k++) begin
      tick(1);
      check_eq($sformatf("periodic irq E%0d", k), irq_val(),
               (k >= 5 && ((k - 5) % 6) == 0) ? 32'd1 : 32'd0);
    end
    bus_read(TC_CTRL, rd);
    check_eq("periodic en kept", rd, 32'hB);

    // Disable mid-count, restart, PRESET change during CNT, reset mid-count
    reset_dut();
    bus_write(TC_PRESET, 32'd100);
    bus_write(TC_CTRL, 32'h9);
    tick(9);
    bus_write(TC_CTRL, 32'h8);
    tick(5);
    bus_read(TC_COUNT, rd);
    check_eq("disable freeze", rd, 32'd92);
    check_eq("disable irq", irq_val(), 32'd0);
    bus_write(TC_CTRL, 32'h9);
    tick(2);
    bus_read(TC_COUNT, rd);
    check_eq("restart reload", rd, 32'd100);
    bus_write(TC_PRESET, 32'd50);
    bus_read(TC_COUNT, rd);
    check_eq("preset write in cnt", rd, 32'd99);
    tick(1);
    bus_read(TC_COUNT, rd);
    check_eq("still counting", rd, 32'd98);
    reset_dut();
    for (int a = 0; a < 3; a++) begin
      bus_read(2'(a), rd);
      check_eq($sformatf("midcount reset addr%0d", a), rd, 32'd0);
    end
    check_eq("midcount reset irq", irq_val(), 32'd0);
    tick(3);
    bus_read(TC_COUNT, rd);
    check_eq("stays idle after reset", rd, 32'd0);

    // Masked periodic, then unmask: irq at the next INT
    reset_dut();
    bus_write(TC_PRESET, 32'd2);
    bus_write(TC_CTRL, 32'h3);
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      check_eq($sformatf("masked irq E%0d", k), irq_val(), 32'd0);
    end
    bus_write(TC_CTRL, 32'hB);
    for (int j = 1; j <= 8; j++) begin
      tick(1);
      check_eq($sformatf("unmasked irq +%0d", j), irq_val(),
               (j == 3 || j == 8) ? 32'd1 : 32'd0);
    end

    // Write CTRL on the edge leaving INT: En survives and the timer restarts
    reset_dut();
    bus_write(TC_PRESET, 32'd2);
    bus_write(TC_CTRL, 32'h9);
    tick(4);
    check_eq("collision int irq", irq_val(), 32'd1);
    bus_write(TC_CTRL, 32'h9);
    bus_read(TC_CTRL, rd);
    check_eq("collision en kept", rd, 32'h9);
    check_eq("collision flag cleared", irq_val(), 32'd0);
    tick(4);
    check_eq("collision restart irq", irq_val(), 32'd1);

    // PRESET=0 behaves as 1
    reset_dut();
    bus_write(TC_PRESET, 32'd0);
    bus_write(TC_CTRL, 32'h9);
    tick(2);
    check_eq("preset0 irq E2", irq_val(), 32'd0);
    tick(1);
    check_eq("preset0 irq E3", irq_val(), 32'd1);

    // PRESET=all ones, disable at E5
    reset_dut();
    bus_write(TC_PRESET, 32'hFFFF_FFFF);
    bus_write(TC_CTRL, 32'h1);
    tick(4);
    bus_write(TC_CTRL, 32'h0);
    tick(2);
    bus_read(TC_COUNT, rd);
    check_eq("max preset count", rd, 32'hFFFF_FFFC);

    // Reserved address, read-only COUNT, CTRL upper bits
    bus_write(2'd3, 32'hDEAD_BEEF);
    bus_read(2'd3, rd);
    check_eq("reserved addr", rd, 32'd0);
    bus_write(TC_COUNT, 32'h1234);
    bus_read(TC_COUNT, rd);
    check_eq("count read only", rd, 32'hFFFF_FFFC);
    bus_write(TC_CTRL, 32'hFFFF_FFF0);
    bus_read(TC_CTRL, rd);
    check_eq("ctrl upper bits", rd, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
